stopwatch_ctrl: RTL



---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_ctrl_bcd_digit.sv | 30 +++
 rtl/stopwatch_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and digit constants for the MM:SS stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam int DIG_W         = 4;
    localparam int SEC_UNITS_MOD = 10;
    localparam int SEC_TENS_MOD  = 6;
    localparam int MIN_UNITS_MOD = 10;
    localparam int MIN_TENS_MOD  = 6;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One modulo-MOD BCD digit with synchronous clear and a terminal-count flag.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [DIG_W-1:0] q,
    output logic             term
);

    localparam logic [DIG_W-1:0] LAST = DIG_W'(MOD - 1);

    assign term = (q == LAST);

    // Clear has priority over counting; the digit wraps to 0 after LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= term ? '0 : q + DIG_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: run/pause FSM, 1 s prescaler and BCD digit cascade.
// Optional lap freeze of the display is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV  = 50_000_000,
    parameter int PRE_BITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] disp,
    output logic        running,
    output logic        tick,
    output logic        overflow
);

    localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(CLK_DIV - 1);

    state_t              state;
    logic [PRE_BITS-1:0] prescaler;

    logic [DIG_W-1:0] sec_units, sec_tens, min_units, min_tens;
    logic             sec_units_term, sec_tens_term, min_units_term, min_tens_term;
    logic             en_sec_tens, en_min_units, en_min_tens, wrap;
    logic             digit_clr;
    logic [15:0]      live;

    assign tick         = (state == RUN) && (prescaler == PRE_LAST);
    assign en_sec_tens  = tick && sec_units_term;
    assign en_min_units = en_sec_tens && sec_tens_term;
    assign en_min_tens  = en_min_units && min_units_term;
    assign wrap         = en_min_tens && min_tens_term;
    // Clear is only honoured outside RUN, which is also when it beats start_stop.
    assign digit_clr    = clear && (state != RUN);
    assign live         = {min_tens, min_units, sec_tens, sec_units};

    bcd_digit #(.MOD(SEC_UNITS_MOD)) u_sec_units (
        .clk(clk), .rst(rst), .en(tick), .clr(digit_clr),
        .q(sec_units), .term(sec_units_term)
    );

    bcd_digit #(.MOD(SEC_TENS_MOD)) u_sec_tens (
        .clk(clk), .rst(rst), .en(en_sec_tens), .clr(digit_clr),
        .q(sec_tens), .term(sec_tens_term)
    );

    bcd_digit #(.MOD(MIN_UNITS_MOD)) u_min_units (
        .clk(clk), .rst(rst), .en(en_min_units), .clr(digit_clr),
        .q(min_units), .term(min_units_term)
    );

    bcd_digit #(.MOD(MIN_TENS_MOD)) u_min_tens (
        .clk(clk), .rst(rst), .en(en_min_tens), .clr(digit_clr),
        .q(min_tens), .term(min_tens_term)
    );

    // The prescaler only advances in RUN, so a pause keeps the partial second.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            prescaler <= '0;
            running   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        prescaler <= '0;
                        overflow  <= 1'b0;
                    end else if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    prescaler <= tick ? '0 : prescaler + PRE_BITS'(1);
                    if (wrap) begin
                        overflow <= 1'b1;
                    end
                    if (start_stop) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (clear) begin
                        state     <= IDLE;
                        running   <= 1'b0;
                        prescaler <= '0;
                        overflow  <= 1'b0;
                    end else if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running   <= 1'b0;
                    prescaler <= '0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        hold;
    logic [15:0] held;

    // The snapshot is the display value in the cycle the lap pulse arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= 1'b0;
            held <= '0;
        end else if (digit_clr) begin
            hold <= 1'b0;
        end else if (lap && (state != IDLE)) begin
            hold <= ~hold;
            if (!hold) begin
                held <= live;
            end
        end
    end

    assign disp = hold ? held : live;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign disp       = live;
`endif

endmodule
